// File: rtl/lif_spike_layer_if.sv
// lif_spike_layer_if
//   Bundles the run/clear controls, the MVM result stream and the spike
//   outputs of the LIF neuron stage.
//   master : drives enable, in_clear, in_val, in_toggle; observes outputs.
//   slave  : the neuron stage itself.
interface lif_spike_layer_if;
  logic       enable;
  logic       in_clear;
  logic [7:0] in_val;
  logic       in_toggle;
  logic [2:0] spike_out;
  logic       spike_valid;
  logic [7:0] frame_count;
  logic       busy;

  modport master (
    output enable, in_clear, in_val, in_toggle,
    input  spike_out, spike_valid, frame_count, busy
  );

  modport slave (
    input  enable, in_clear, in_val, in_toggle,
    output spike_out, spike_valid, frame_count, busy
  );
endinterface

// File: rtl/lif_spike_layer.sv
// lif_spike_layer
//   Three-neuron leaky integrate-and-fire stage fed by the MVM result stream.
//   Every level change of in_toggle carries one 8-bit value for neuron idx
//   (0,1,2 in turn). After the third value of a frame the spike vector is
//   published with a one-cycle spike_valid pulse.
//   Ports:
//     clk   : clock
//     rst_n : asynchronous active-low reset
//     bus   : lif_spike_layer_if.slave (enable, in_clear, in_val, in_toggle,
//             spike_out, spike_valid, frame_count, busy)
module lif_spike_layer #(
  parameter int V_WIDTH    = 10,
  parameter int THRESHOLD  = 100,
  parameter int LEAK_SHIFT = 2,
  parameter int REFRACT    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  lif_spike_layer_if.slave         bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_q, state_d;
  logic                      tog_q, tog_d;
  logic [1:0]                idx_q, idx_d;
  logic [2:0][V_WIDTH-1:0]   v_q, v_d;
  logic [2:0][1:0]           refract_q, refract_d;
  logic [2:0]                acc_q, acc_d;
  logic [2:0]                spike_out_q, spike_out_d;
  logic                      spike_valid_q, spike_valid_d;
  logic [7:0]                frame_count_q, frame_count_d;
  logic                      busy_q, busy_d;

  logic [2:0][V_WIDTH-1:0]   sat_val;
  logic [2:0]                fire;
  logic                      accept;
  logic                      cur_bit;

  // Candidate update for every neuron; only the one at idx is committed.
  // One extra bit holds v - leak + in_val so overflow can be saturated.
  for (genvar gi = 0; gi < 3; gi++) begin : g_neuron
    logic [V_WIDTH:0] v_ext;
    logic [V_WIDTH:0] sum;
    assign v_ext         = {1'b0, v_q[gi]};
    assign sum           = v_ext - (v_ext >> LEAK_SHIFT) + (V_WIDTH+1)'(bus.in_val);
    assign sat_val[gi]   = sum[V_WIDTH] ? {V_WIDTH{1'b1}} : sum[V_WIDTH-1:0];
    assign fire[gi]      = (sat_val[gi] >= V_WIDTH'(THRESHOLD));
  end

  // With enable low at a frame boundary nothing new is started; a frame that
  // is already under way is still allowed to finish.
  assign accept = (state_q == RUN) && (bus.in_toggle != tog_q) &&
                  (bus.enable || (idx_q != 2'd0));

  always_comb begin
    state_d       = state_q;
    tog_d         = bus.in_toggle;
    idx_d         = idx_q;
    v_d           = v_q;
    refract_d     = refract_q;
    acc_d         = acc_q;
    spike_out_d   = spike_out_q;
    spike_valid_d = 1'b0;
    frame_count_d = frame_count_q;
    cur_bit       = 1'b0;

    if (bus.in_clear) begin
      // tog_d already follows in_toggle, so a toggle this cycle is dropped.
      v_d       = '0;
      refract_d = '0;
      idx_d     = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enable) state_d = RUN;
        end
        RUN: begin
          if (!bus.enable && (idx_q == 2'd0)) state_d = IDLE;
          if (accept) begin
            if (refract_q[idx_q] != 2'd0) begin
              refract_d[idx_q] = refract_q[idx_q] - 2'd1;
              v_d[idx_q]       = '0;
            end else if (fire[idx_q]) begin
              cur_bit          = 1'b1;
              v_d[idx_q]       = '0;
              refract_d[idx_q] = 2'(REFRACT);
            end else begin
              v_d[idx_q]       = sat_val[idx_q];
            end
            acc_d[idx_q] = cur_bit;
            if (idx_q == 2'd2) begin
              idx_d         = 2'd0;
              spike_out_d   = acc_d;
              spike_valid_d = 1'b1;
              frame_count_d = frame_count_q + 8'd1;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (idx_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tog_q         <= 1'b0;
      idx_q         <= 2'd0;
      v_q           <= '0;
      refract_q     <= '0;
      acc_q         <= '0;
      spike_out_q   <= '0;
      spike_valid_q <= 1'b0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tog_q         <= tog_d;
      idx_q         <= idx_d;
      v_q           <= v_d;
      refract_q     <= refract_d;
      acc_q         <= acc_d;
      spike_out_q   <= spike_out_d;
      spike_valid_q <= spike_valid_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.spike_out   = spike_out_q;
  assign bus.spike_valid = spike_valid_q;
  assign bus.frame_count = frame_count_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_lif_spike_layer.sv
// Directed bench for lif_spike_layer: default-parameter instance for the
// functional scenarios and a LEAK_SHIFT=8 / THRESHOLD=1023 instance for
// saturation.
module tb_lif_spike_layer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lif_spike_layer_if bus_a ();
  lif_spike_layer_if bus_b ();

  lif_spike_layer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  lif_spike_layer #(.THRESHOLD(1023), .LEAK_SHIFT(8)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic send_a(input logic [7:0] val);
    @(negedge clk);
    bus_a.in_val    = val;
    bus_a.in_toggle = ~bus_a.in_toggle;
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [7:0] val);
    @(negedge clk);
    bus_b.in_val    = val;
    bus_b.in_toggle = ~bus_b.in_toggle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    @(negedge clk);
    bus_a.in_clear = 1'b1;
    @(negedge clk);
    bus_a.in_clear = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (bus_a.spike_out !== 3'b000) begin miscompares++; $display("FAIL reset_spike_out got %b want 000", bus_a.spike_out); end
    vectors++; if (bus_a.spike_valid !== 1'b0) begin miscompares++; $display("FAIL reset_spike_valid got %b want 0", bus_a.spike_valid); end
    vectors++; if (bus_a.frame_count !== 8'd0) begin miscompares++; $display("FAIL reset_frame_count got %0d want 0", bus_a.frame_count); end
    vectors++; if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus_a.busy); end
    $display("reset: spike_out=%b frame_count=%0d busy=%b", bus_a.spike_out, bus_a.frame_count, bus_a.busy);
  endtask

  // Toggle in the same cycle enable rises in IDLE must be dropped.
  task automatic test_enable_rise();
    @(negedge clk);
    bus_a.enable    = 1'b1;
    bus_a.in_toggle = ~bus_a.in_toggle;
    @(posedge clk);
    #1;
    vectors++; if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL enable_rise_drop busy got %b want 0", bus_a.busy); end
    $display("enable_rise: busy=%b", bus_a.busy);
  endtask

  task automatic test_basic_frame();
    send_a(8'd50);
    vectors++; if (bus_a.busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %b want 1", bus_a.busy); end
    send_a(8'd0);
    send_a(8'd120);
    $display("frame1: spike_out=%b valid=%b fc=%0d v0=%0d", bus_a.spike_out, bus_a.spike_valid, bus_a.frame_count, dut.v_q[0]);
    vectors++; if (bus_a.spike_out !== 3'b100) begin miscompares++; $display("FAIL f1_spike_out got %b want 100", bus_a.spike_out); end
    vectors++; if (bus_a.spike_valid !== 1'b1) begin miscompares++; $display("FAIL f1_valid got %b want 1", bus_a.spike_valid); end
    vectors++; if (bus_a.frame_count !== 8'd1) begin miscompares++; $display("FAIL f1_frame_count got %0d want 1", bus_a.frame_count); end
    vectors++; if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL f1_busy got %b want 0", bus_a.busy); end
    vectors++; if (dut.v_q[0] !== 10'd50) begin miscompares++; $display("FAIL f1_v0 got %0d want 50", dut.v_q[0]); end
    vectors++; if (dut.v_q[2] !== 10'd0) begin miscompares++; $display("FAIL f1_v2 got %0d want 0", dut.v_q[2]); end
    @(posedge clk); #1;
    vectors++; if (bus_a.spike_valid !== 1'b0) begin miscompares++; $display("FAIL f1_valid_n2 got %b want 0", bus_a.spike_valid); end
    send_a(8'd60);
    send_a(8'd0);
    send_a(8'd90);
    $display("frame2: spike_out=%b fc=%0d v0=%0d refract2=%0d", bus_a.spike_out, bus_a.frame_count, dut.v_q[0], dut.refract_q[2]);
    vectors++; if (bus_a.spike_out !== 3'b000) begin miscompares++; $display("FAIL f2_spike_out got %b want 000", bus_a.spike_out); end
    vectors++; if (dut.v_q[0] !== 10'd98) begin miscompares++; $display("FAIL f2_v0 got %0d want 98", dut.v_q[0]); end
    vectors++; if (dut.v_q[2] !== 10'd0) begin miscompares++; $display("FAIL f2_v2 got %0d want 0", dut.v_q[2]); end
    vectors++; if (dut.refract_q[2] !== 2'd1) begin miscompares++; $display("FAIL f2_refract2 got %0d want 1", dut.refract_q[2]); end
    vectors++; if (bus_a.frame_count !== 8'd2) begin miscompares++; $display("FAIL f2_frame_count got %0d want 2", bus_a.frame_count); end
  endtask

  // Six toggles on six consecutive cycles: frames (100,100,100) then (0,0,0).
  task automatic test_back_to_back();
    logic [7:0] vals [6] = '{8'd100, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0};
    clear_a();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus_a.in_val    = vals[k-1];
      bus_a.in_toggle = ~bus_a.in_toggle;
      @(posedge clk);
      #1;
      $display("b2b %0d: valid=%b spike_out=%b fc=%0d", k, bus_a.spike_valid, bus_a.spike_out, bus_a.frame_count);
      vectors++; if (bus_a.spike_valid !== ((k % 3) == 0)) begin miscompares++; $display("FAIL b2b_valid_%0d got %b want %b", k, bus_a.spike_valid, ((k % 3) == 0)); end
      if (k == 3) begin
        vectors++; if (bus_a.spike_out !== 3'b111) begin miscompares++; $display("FAIL b2b_spike_a got %b want 111", bus_a.spike_out); end
      end
      if (k == 6) begin
        vectors++; if (bus_a.spike_out !== 3'b000) begin miscompares++; $display("FAIL b2b_spike_b got %b want 000", bus_a.spike_out); end
      end
    end
    @(posedge clk); #1;
    vectors++; if (bus_a.spike_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_end got %b want 0", bus_a.spike_valid); end
    vectors++; if (bus_a.frame_count !== 8'd4) begin miscompares++; $display("FAIL b2b_frame_count got %0d want 4", bus_a.frame_count); end
  endtask

  task automatic test_mid_frame_clear();
    clear_a();
    send_a(8'd30);
    send_a(8'd40);
    vectors++; if (dut.v_q[0] !== 10'd30) begin miscompares++; $display("FAIL clr_pre_v0 got %0d want 30", dut.v_q[0]); end
    // Clear together with a toggle: value must be dropped.
    @(negedge clk);
    bus_a.in_clear  = 1'b1;
    bus_a.in_val    = 8'd99;
    bus_a.in_toggle = ~bus_a.in_toggle;
    @(posedge clk); #1;
    $display("clear: busy=%b v0=%0d v1=%0d spike_out=%b fc=%0d", bus_a.busy, dut.v_q[0], dut.v_q[1], bus_a.spike_out, bus_a.frame_count);
    vectors++; if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL clr_busy got %b want 0", bus_a.busy); end
    vectors++; if (dut.v_q[0] !== 10'd0) begin miscompares++; $display("FAIL clr_v0 got %0d want 0", dut.v_q[0]); end
    vectors++; if (dut.v_q[1] !== 10'd0) begin miscompares++; $display("FAIL clr_v1 got %0d want 0", dut.v_q[1]); end
    vectors++; if (bus_a.spike_out !== 3'b000) begin miscompares++; $display("FAIL clr_spike_out got %b want 000", bus_a.spike_out); end
    vectors++; if (bus_a.frame_count !== 8'd4) begin miscompares++; $display("FAIL clr_frame_count got %0d want 4", bus_a.frame_count); end
    @(negedge clk);
    bus_a.in_clear = 1'b0;
    @(posedge clk); #1;
    vectors++; if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL clr_no_false_capture busy got %b want 0", bus_a.busy); end
    send_a(8'd10);
    send_a(8'd20);
    send_a(8'd110);
    $display("post-clear frame: spike_out=%b fc=%0d v0=%0d", bus_a.spike_out, bus_a.frame_count, dut.v_q[0]);
    vectors++; if (bus_a.spike_out !== 3'b100) begin miscompares++; $display("FAIL clr_frame_spike got %b want 100", bus_a.spike_out); end
    vectors++; if (bus_a.frame_count !== 8'd5) begin miscompares++; $display("FAIL clr_frame_count2 got %0d want 5", bus_a.frame_count); end
    vectors++; if (dut.v_q[0] !== 10'd10) begin miscompares++; $display("FAIL clr_frame_v0 got %0d want 10", dut.v_q[0]); end
  endtask

  task automatic test_enable_drop();
    clear_a();
    send_a(8'd200);
    @(negedge clk);
    bus_a.enable = 1'b0;
    send_a(8'd0);
    send_a(8'd0);
    $display("enable_drop frame: spike_out=%b valid=%b fc=%0d", bus_a.spike_out, bus_a.spike_valid, bus_a.frame_count);
    vectors++; if (bus_a.spike_out !== 3'b001) begin miscompares++; $display("FAIL endrop_spike got %b want 001", bus_a.spike_out); end
    vectors++; if (bus_a.spike_valid !== 1'b1) begin miscompares++; $display("FAIL endrop_valid got %b want 1", bus_a.spike_valid); end
    vectors++; if (bus_a.frame_count !== 8'd6) begin miscompares++; $display("FAIL endrop_frame_count got %0d want 6", bus_a.frame_count); end
    for (int k = 0; k < 4; k++) begin
      send_a(8'd77);
      vectors++; if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL endrop_ignored_busy_%0d got %b want 0", k, bus_a.busy); end
    end
    $display("idle toggles: busy=%b fc=%0d", bus_a.busy, bus_a.frame_count);
    vectors++; if (bus_a.frame_count !== 8'd6) begin miscompares++; $display("FAIL endrop_frozen got %0d want 6", bus_a.frame_count); end
    test_enable_rise();
  endtask

  task automatic test_async_reset();
    send_a(8'd0);
    send_a(8'd0);
    send_a(8'd150);
    vectors++; if (bus_a.spike_out !== 3'b100) begin miscompares++; $display("FAIL ar_pre_spike got %b want 100", bus_a.spike_out); end
    vectors++; if (bus_a.frame_count !== 8'd7) begin miscompares++; $display("FAIL ar_pre_fc got %0d want 7", bus_a.frame_count); end
    send_a(8'd50);
    vectors++; if (bus_a.busy !== 1'b1) begin miscompares++; $display("FAIL ar_pre_busy got %b want 1", bus_a.busy); end
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: spike_out=%b valid=%b fc=%0d busy=%b", bus_a.spike_out, bus_a.spike_valid, bus_a.frame_count, bus_a.busy);
    vectors++; if (bus_a.spike_out !== 3'b000) begin miscompares++; $display("FAIL ar_spike got %b want 000", bus_a.spike_out); end
    vectors++; if (bus_a.spike_valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid got %b want 0", bus_a.spike_valid); end
    vectors++; if (bus_a.frame_count !== 8'd0) begin miscompares++; $display("FAIL ar_fc got %0d want 0", bus_a.frame_count); end
    vectors++; if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL ar_busy got %b want 0", bus_a.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    send_a(8'd70);
    send_a(8'd80);
    send_a(8'd120);
    $display("post-reset frame: spike_out=%b valid=%b fc=%0d v0=%0d", bus_a.spike_out, bus_a.spike_valid, bus_a.frame_count, dut.v_q[0]);
    vectors++; if (bus_a.spike_out !== 3'b100) begin miscompares++; $display("FAIL ar_post_spike got %b want 100", bus_a.spike_out); end
    vectors++; if (bus_a.spike_valid !== 1'b1) begin miscompares++; $display("FAIL ar_post_valid got %b want 1", bus_a.spike_valid); end
    vectors++; if (bus_a.frame_count !== 8'd1) begin miscompares++; $display("FAIL ar_post_fc got %0d want 1", bus_a.frame_count); end
    vectors++; if (dut.v_q[0] !== 10'd70) begin miscompares++; $display("FAIL ar_post_v0 got %0d want 70", dut.v_q[0]); end
  endtask

  // 255 per frame into neuron 0 with leak v>>8 and threshold 1023.
  task automatic test_saturation();
    logic [9:0] exp_v [5]   = '{10'd255, 10'd510, 10'd764, 10'd1017, 10'd0};
    logic       exp_spk [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    bus_b.enable = 1'b1;
    @(posedge clk);
    for (int f = 0; f < 5; f++) begin
      send_b(8'd255);
      send_b(8'd0);
      send_b(8'd0);
      $display("sat frame %0d: v0=%0d spike_out=%b", f + 1, dut_sat.v_q[0], bus_b.spike_out);
      vectors++; if (dut_sat.v_q[0] !== exp_v[f]) begin miscompares++; $display("FAIL sat_v0_f%0d got %0d want %0d", f + 1, dut_sat.v_q[0], exp_v[f]); end
      vectors++; if (bus_b.spike_out[0] !== exp_spk[f]) begin miscompares++; $display("FAIL sat_spike_f%0d got %b want %b", f + 1, bus_b.spike_out[0], exp_spk[f]); end
    end
    vectors++; if (bus_b.frame_count !== 8'd5) begin miscompares++; $display("FAIL sat_fc got %0d want 5", bus_b.frame_count); end
  endtask

  initial begin
    bus_a.enable = 1'b0; bus_a.in_clear = 1'b0; bus_a.in_val = 8'd0; bus_a.in_toggle = 1'b0;
    bus_b.enable = 1'b0; bus_b.in_clear = 1'b0; bus_b.in_val = 8'd0; bus_b.in_toggle = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_enable_rise();
    test_basic_frame();
    test_back_to_back();
    test_mid_frame_clear();
    test_enable_drop();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
